hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Hazard detection and forwarding control for the 5-stage RISC-V core. Tracks destination-register state of the instructions in EX and MEM, decodes source-register usage of the instruction in ID, and produces registered 2-bit operand select codes that drive the EX-stage operand forwarding muxes. It also detects load-use hazards and runs a one-cycle stall/bubble sequence, and squashes tracking state on branch flush.

## Interface
- XLEN_CNT, 32, width of the optional stall counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- pipe_hold  input  1  global freeze (memory wait); all state holds
- flush  input  1  taken branch/jump resolved in EX; squash ID instruction
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  5  ID source registers
- id_rs1_used, id_rs2_used  input  1  source actually read by the instruction
- id_rd  input  5  ID destination register
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- operand1_select, operand2_select  output  2  registered select for EX muxes: 00 = register file, 10 = EX/MEM result, 11 = MEM/WB result (01 never driven)
- stall  output  1  freeze PC and IF/ID this cycle
- bubble  output  1  registered; EX holds an inserted NOP
- stall_count  output  XLEN_CNT  load-use stall cycles (only with macro)

## Operation
- Tracking registers: ex_rd/ex_wr/ex_ld (instruction in EX), mem_rd/mem_wr (instruction in MEM). Each non-held edge: MEM <- EX, EX <- ID (or bubble).
- Forward match (per source s): EX match = id_valid & s_used & ex_wr & ex_rd==s & s!=0 -> select 10; else MEM match = mem_wr & mem_rd==s & s!=0 -> select 11; else 00. EX match has priority.
- Load-use: stall = id_valid & ex_ld & ex_wr & ex_rd!=0 & (rs1 or rs2 used and equal ex_rd) & !flush & !pipe_hold.
- FSM RUN / BUBBLE: RUN + stall -> BUBBLE; BUBBLE -> RUN unconditionally. On entering BUBBLE, EX tracking loads zeros (wr=0, ld=0), selects load 00, bubble=1. ID instruction is held and re-evaluated in BUBBLE; the load is now in MEM, giving select 11.
- Flush: EX tracking loads zeros, selects 00, bubble=1, FSM -> RUN. MEM still receives the prior EX (the branch).
- Priority: rst_n > pipe_hold > flush > stall > normal.
- rd=x0 never forwarded or stalled on.

## Timing
- Selects and bubble are registered: decided in ID at edge N, valid in EX during cycle N+1.
- stall is combinational from ID inputs and EX tracking; asserted for exactly one cycle per load-use hazard.
- Load-use penalty: exactly 1 cycle.
- pipe_hold high: no state change, stall forced 0, outputs hold previous values.
- Reset (asynchronous, any time, including mid-BUBBLE): tracking cleared, FSM=RUN, selects=00, bubble=0, stall=0, stall_count=0.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_count increments by 1 on every edge where stall=1 and pipe_hold=0; wraps at 2^XLEN_CNT-1 -> 0.
- Not defined: port stall_count absent, no counter logic.

## Test plan
- add x5 then add x6,x5,x1 back-to-back -> operand1_select=10 in EX of second, stall never asserted.
- add x5; nop; sub x7,x1,x5 -> operand2_select=11 for sub.
- x5 written by both EX and MEM instructions, ID reads x5 -> select 10 (EX priority).
- lw x5; add x6,x5,x5 -> stall=1 for one cycle, bubble=1, then both selects 11; stall_count=1 with macro.
- lw x0 followed by reader of x0 -> no stall, selects 00.
- flush asserted in same cycle as load-use hazard -> stall=0, bubble=1, selects 00; reset asserted mid-BUBBLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID decode fields in, forwarding selects and stall/bubble out.
// Latency: none (wires only); selects/bubble are registered inside the hazard unit.
// Backpressure: pipe_hold freezes the unit; stall is the unit's backpressure to PC and IF/ID.
// Optional stall_count member exists only when HAZARD_STALL_CNT_EN is defined.
interface hazard_forward_ctrl_if
`ifdef HAZARD_STALL_CNT_EN
   #(parameter int XLEN_CNT = 32)
`endif
   ;
   logic       pipe_hold;
   logic       flush;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic [1:0] operand1_select;
   logic [1:0] operand2_select;
   logic       stall;
   logic       bubble;
`ifdef HAZARD_STALL_CNT_EN
   logic [XLEN_CNT-1:0] stall_count;
`endif

   // Pipeline side: drives decode fields, consumes selects and stall.
   modport master (
      output pipe_hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_reg_write, id_mem_read,
`ifdef HAZARD_STALL_CNT_EN
      input  stall_count,
`endif
      input  operand1_select, operand2_select, stall, bubble
   );

   // Hazard unit side.
   modport slave (
      input  pipe_hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_reg_write, id_mem_read,
`ifdef HAZARD_STALL_CNT_EN
      output stall_count,
`endif
      output operand1_select, operand2_select, stall, bubble
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection / EX operand forwarding control for the 5-stage core (optional macro HAZARD_STALL_CNT_EN).
// Latency: selects and bubble registered (decided in ID, valid in EX next cycle); stall is combinational.
// Backpressure: pipe_hold freezes all state; load-use raises stall for one cycle and inserts one bubble.
module hazard_forward_ctrl (
   input  logic                  clk,
   input  logic                  rst_n,
   hazard_forward_ctrl_if.slave  hz
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EXM = 2'b10;
   localparam logic [1:0] SEL_MWB = 2'b11;

   typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

   state_t     state_q;
   logic [4:0] ex_rd_q;
   logic       ex_wr_q;
   logic       ex_ld_q;
   logic [4:0] mem_rd_q;
   logic       mem_wr_q;
   logic [1:0] sel1_q;
   logic [1:0] sel2_q;
   logic       bubble_q;

   logic [1:0] sel1_d;
   logic [1:0] sel2_d;
   logic       load_use;
   logic       stall_c;

   // Forward source for one operand; an unread source or x0 always takes the register file.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       used,
      input logic       vld,
      input logic [4:0] ex_rd,
      input logic       ex_wr,
      input logic [4:0] mem_rd,
      input logic       mem_wr
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (vld && used && (src != 5'd0)) begin
         if (ex_wr && (ex_rd == src))
            sel = SEL_EXM;
         else if (mem_wr && (mem_rd == src))
            sel = SEL_MWB;
      end
      return sel;
   endfunction

   // Next-cycle selects and the load-use hazard detect from ID fields and EX/MEM tracking.
   always_comb begin
      sel1_d   = fwd_sel(hz.id_rs1, hz.id_rs1_used, hz.id_valid,
                         ex_rd_q, ex_wr_q, mem_rd_q, mem_wr_q);
      sel2_d   = fwd_sel(hz.id_rs2, hz.id_rs2_used, hz.id_valid,
                         ex_rd_q, ex_wr_q, mem_rd_q, mem_wr_q);
      load_use = hz.id_valid && ex_ld_q && ex_wr_q && (ex_rd_q != 5'd0) &&
                 ((hz.id_rs1_used && (hz.id_rs1 == ex_rd_q)) ||
                  (hz.id_rs2_used && (hz.id_rs2 == ex_rd_q)));
      // Flush kills the ID instruction, so its hazard is moot; hold freezes everything.
      stall_c  = load_use && !hz.flush && !hz.pipe_hold;
   end

   // RUN/BUBBLE sequencer plus EX/MEM tracking and registered EX-stage outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         ex_rd_q  <= 5'd0;
         ex_wr_q  <= 1'b0;
         ex_ld_q  <= 1'b0;
         mem_rd_q <= 5'd0;
         mem_wr_q <= 1'b0;
         sel1_q   <= SEL_RF;
         sel2_q   <= SEL_RF;
         bubble_q <= 1'b0;
      end else if (!hz.pipe_hold) begin
         // MEM always inherits EX, including a branch that is flushing its successor.
         mem_rd_q <= ex_rd_q;
         mem_wr_q <= ex_wr_q;
         if (hz.flush || stall_c) begin
            // EX receives a NOP: nothing to forward from it next cycle.
            ex_rd_q  <= 5'd0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            sel1_q   <= SEL_RF;
            sel2_q   <= SEL_RF;
            bubble_q <= 1'b1;
         end else begin
            ex_rd_q  <= hz.id_rd;
            ex_wr_q  <= hz.id_valid && hz.id_reg_write;
            ex_ld_q  <= hz.id_valid && hz.id_mem_read;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            bubble_q <= 1'b0;
         end
         case (state_q)
            ST_RUN:    state_q <= (stall_c && !hz.flush) ? ST_BUBBLE : ST_RUN;
            // The held ID instruction re-evaluates here with the load now in MEM.
            ST_BUBBLE: state_q <= ST_RUN;
            default:   state_q <= ST_RUN;
         endcase
      end
   end

   assign hz.operand1_select = sel1_q;
   assign hz.operand2_select = sel2_q;
   assign hz.bubble          = bubble_q;
   assign hz.stall           = stall_c;

`ifdef HAZARD_STALL_CNT_EN
   logic [$bits(hz.stall_count)-1:0] stall_cnt_q;

   // Count load-use stall cycles; free-running wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (stall_c)
         stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign hz.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized + directed bench for hazard_forward_ctrl with a queue-based scoreboard.
// Expected selects/bubble/stall come from a slot-level pipeline model of the hazard rules.
// A negedge monitor pops expectations and compares against the DUT.
module tb_hazard_forward_ctrl;

   typedef struct {
      bit       v;
      bit [4:0] rs1;
      bit       u1;
      bit [4:0] rs2;
      bit       u2;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
   } instr_t;

   // What an instruction in a pipeline slot means for hazards.
   typedef struct {
      bit       wr;
      bit       ld;
      bit [4:0] rd;
   } slot_t;

   typedef struct {
      bit [1:0]  s1;
      bit [1:0]  s2;
      bit        bub;
      bit [31:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   hazard_forward_ctrl_if hz();

   hazard_forward_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   int    n_chk  = 0;
   int    n_fail = 0;
   exp_t  exp_reg_q[$];
   bit    exp_stall_q[$];
   slot_t m_ex, m_mem;
   exp_t  m_out;
   bit    last_stall;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t mk(input bit v, input bit [4:0] rd, input bit wr, input bit ld,
                                 input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
      instr_t i;
      i.v = v; i.rd = rd; i.wr = wr; i.ld = ld;
      i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
      return i;
   endfunction

   function automatic instr_t op_add(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
      return mk(1, rd, 1, 0, rs1, 1, rs2, 1);
   endfunction

   function automatic instr_t op_lw(input bit [4:0] rd, input bit [4:0] rs1);
      return mk(1, rd, 1, 1, rs1, 1, 5'd0, 0);
   endfunction

   function automatic instr_t op_nop();
      return mk(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
   endfunction

   // A reader of a load result sitting right behind the load must wait one cycle.
   function automatic bit model_stall();
      bit reads;
      reads = (hz.id_rs1_used && hz.id_rs1 == m_ex.rd) || (hz.id_rs2_used && hz.id_rs2 == m_ex.rd);
      return hz.id_valid && m_ex.ld && m_ex.wr && m_ex.rd != 5'd0 && reads &&
             !hz.flush && !hz.pipe_hold;
   endfunction

   // Youngest producer of src wins: EX result first, then MEM/WB, else the register file.
   function automatic bit [1:0] model_sel(input bit [4:0] src, input bit used);
      if (!(hz.id_valid && used) || src == 5'd0) return 2'b00;
      if (m_ex.wr && m_ex.rd == src)             return 2'b10;
      if (m_mem.wr && m_mem.rd == src)           return 2'b11;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ex  = '{wr: 0, ld: 0, rd: 0};
      m_mem = '{wr: 0, ld: 0, rd: 0};
      m_out = '{s1: 0, s2: 0, bub: 0, cnt: 0};
   endtask

   // Advance the model across the clock edge that just happened, using the inputs it sampled.
   task automatic model_edge();
      bit st;
      st = model_stall();
      if (!hz.pipe_hold) begin
         if (hz.flush || st) begin
            m_out.s1  = 2'b00;
            m_out.s2  = 2'b00;
            m_out.bub = 1'b1;
            m_mem     = m_ex;
            m_ex      = '{wr: 0, ld: 0, rd: 0};
         end else begin
            m_out.s1  = model_sel(hz.id_rs1, hz.id_rs1_used);
            m_out.s2  = model_sel(hz.id_rs2, hz.id_rs2_used);
            m_out.bub = 1'b0;
            m_mem     = m_ex;
            m_ex.wr   = hz.id_valid && hz.id_reg_write;
            m_ex.ld   = hz.id_valid && hz.id_mem_read;
            m_ex.rd   = hz.id_rd;
         end
         if (st) m_out.cnt = m_out.cnt + 1;
      end
      exp_reg_q.push_back(m_out);
   endtask

   task automatic apply(input instr_t i, input bit fl, input bit hd);
      hz.id_valid     = i.v;
      hz.id_rs1       = i.rs1;
      hz.id_rs1_used  = i.u1;
      hz.id_rs2       = i.rs2;
      hz.id_rs2_used  = i.u2;
      hz.id_rd        = i.rd;
      hz.id_reg_write = i.wr;
      hz.id_mem_read  = i.ld;
      hz.flush        = fl;
      hz.pipe_hold    = hd;
      last_stall      = model_stall();
      exp_stall_q.push_back(last_stall);
   endtask

   task automatic step(input instr_t i, input bit fl, input bit hd);
      @(posedge clk);
      #1;
      model_edge();
      apply(i, fl, hd);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sel1"},   hz.operand1_select, 0);
      check({tag, "_sel2"},   hz.operand2_select, 0);
      check({tag, "_bubble"}, hz.bubble, 0);
      check({tag, "_stall"},  hz.stall, 0);
`ifdef HAZARD_STALL_CNT_EN
      check({tag, "_count"},  hz.stall_count, 0);
`endif
   endtask

   // Scoreboard monitor: compare whatever expectations were issued this cycle.
   always @(negedge clk) begin
      exp_t e;
      bit   es;
      if (exp_reg_q.size() > 0) begin
         e = exp_reg_q.pop_front();
         check("operand1_select", hz.operand1_select, e.s1);
         check("operand2_select", hz.operand2_select, e.s2);
         check("bubble", hz.bubble, e.bub);
`ifdef HAZARD_STALL_CNT_EN
         check("stall_count", hz.stall_count, e.cnt);
`endif
      end
      if (exp_stall_q.size() > 0) begin
         es = exp_stall_q.pop_front();
         check("stall", hz.stall, es);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t cur;
      bit     fl, hd;
      model_reset();
      rst_n = 1'b0;
      apply(op_nop(), 0, 0);
      void'(exp_stall_q.pop_front());
      #12;
      check_all_zero("reset");
      #10 rst_n = 1'b1;

      // Back-to-back EX forward, no stall.
      step(op_add(5'd5, 5'd1, 5'd2), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd1), 0, 0);
      // MEM forward across one NOP.
      step(op_add(5'd5, 5'd1, 5'd2), 0, 0);
      step(op_nop(), 0, 0);
      step(op_add(5'd7, 5'd1, 5'd5), 0, 0);
      // x5 written in both EX and MEM: EX wins.
      step(op_add(5'd5, 5'd1, 5'd2), 0, 0);
      step(op_add(5'd5, 5'd3, 5'd4), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd0), 0, 0);
      // Load-use: one stall, one bubble, then MEM/WB forwards on both operands.
      step(op_lw(5'd5, 5'd1), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd5), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd5), 0, 0);
      step(op_nop(), 0, 0);
      // Load to x0 never stalls or forwards.
      step(op_lw(5'd0, 5'd1), 0, 0);
      step(op_add(5'd6, 5'd0, 5'd0), 0, 0);
      step(op_nop(), 0, 0);
      // Flush in the same cycle as a load-use hazard.
      step(op_lw(5'd5, 5'd1), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd5), 1, 0);
      step(op_nop(), 0, 0);
      // Hold freezes state while a forwarding decision is pending.
      step(op_add(5'd9, 5'd1, 5'd2), 0, 0);
      step(op_add(5'd8, 5'd9, 5'd9), 0, 1);
      step(op_add(5'd8, 5'd9, 5'd9), 0, 1);
      step(op_add(5'd8, 5'd9, 5'd9), 0, 0);
      // Reset asserted while EX holds the inserted bubble.
      step(op_lw(5'd5, 5'd1), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd5), 0, 0);
      step(op_add(5'd6, 5'd5, 5'd5), 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_bubble_reset");
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Random traffic over a small register set so hazards are frequent.
      cur = op_nop();
      for (int n = 0; n < 600; n++) begin
         fl = ($urandom_range(0, 9) == 0);
         hd = ($urandom_range(0, 9) == 0);
         if (!(last_stall || hz.pipe_hold)) begin
            cur.v   = ($urandom_range(0, 9) != 0);
            cur.rs1 = 5'($urandom_range(0, 3));
            cur.rs2 = 5'($urandom_range(0, 3));
            cur.u1  = ($urandom_range(0, 3) != 0);
            cur.u2  = ($urandom_range(0, 1) != 0);
            cur.rd  = 5'($urandom_range(0, 3));
            cur.wr  = ($urandom_range(0, 4) != 0);
            cur.ld  = ($urandom_range(0, 2) == 0);
         end
         step(cur, fl, hd);
      end
      step(op_nop(), 0, 0);
      @(negedge clk);
      #1;
      check("queues_drained", exp_reg_q.size() + exp_stall_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
